// File: rtl/seq_mixer.sv
// Time-multiplexed channel mixer: one multiply per clock across a frame of
// CHANNELS samples, then master gain, saturation and a one-cycle valid.
module seq_mixer #(
   parameter int WIDTH     = 8,
   parameter int CHANNELS  = 8,
   parameter int VOL_WIDTH = 4
) (
   input  logic                            clk_in,
   input  logic                            rst_in,
   input  logic                            sample_valid_in,
   input  logic [CHANNELS*WIDTH-1:0]       data_dry_in,
   input  logic [CHANNELS*VOL_WIDTH-1:0]   volume_in,
   input  logic [CHANNELS-1:0]             mute_in,
   input  logic [CHANNELS-1:0]             solo_in,
   input  logic [VOL_WIDTH-1:0]            master_in,
   output logic [WIDTH-1:0]                data_wet_out,
   output logic                            wet_valid_out,
   output logic                            clip_out,
   output logic                            overrun_out,
   output logic                            busy_out
);

   localparam int IW = $clog2(CHANNELS);
   localparam int PW = WIDTH + VOL_WIDTH + 1;
   localparam int AW = PW + $clog2(CHANNELS);
   localparam int SW = AW + VOL_WIDTH + 1;
   localparam int SH = 2 * (VOL_WIDTH - 1);

   localparam logic signed [SW-1:0] MAXV = SW'((2 ** (WIDTH - 1)) - 1);
   localparam logic signed [SW-1:0] MINV = ~MAXV;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      SCALE,
      OUT
   } state_t;

   state_t state_q, state_d;

   logic [CHANNELS*WIDTH-1:0]     data_q;
   logic [CHANNELS*VOL_WIDTH-1:0] vol_q;
   logic [CHANNELS-1:0]           en_q;
   logic [VOL_WIDTH-1:0]          master_q;
   logic signed [AW-1:0]          acc_q;
   logic [IW-1:0]                 idx_q;
   logic signed [SW-1:0]          scaled_q;
   logic [WIDTH-1:0]              wet_q;
   logic                          valid_q;
   logic                          clip_q;
   logic                          ovr_q;

   logic                          accept;
   logic                          drop;
   logic                          idx_last;
   logic                          solo_any;
   logic [CHANNELS-1:0]           en_in;
   logic signed [WIDTH-1:0]       smp_sel;
   logic [VOL_WIDTH-1:0]          vol_sel;
   logic signed [PW-1:0]          smp_ext;
   logic signed [PW-1:0]          vol_ext;
   logic signed [PW-1:0]          prod;
   logic signed [AW-1:0]          term;
   logic signed [SW-1:0]          acc_ext;
   logic signed [SW-1:0]          mst_ext;
   logic signed [SW-1:0]          prod_m;
   logic signed [SW-1:0]          scaled_d;
   logic [WIDTH-1:0]              sat_d;
   logic                          clip_d;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      accept   = 1'b0;
      drop     = 1'b0;
      idx_last = (idx_q == IW'(CHANNELS - 1));
      unique case (state_q)
         IDLE: begin
            if (sample_valid_in) begin
               accept  = 1'b1;
               state_d = ACCUM;
            end
         end
         ACCUM: begin
            drop = sample_valid_in;
            if (idx_last) state_d = SCALE;
         end
         SCALE: begin
            drop    = sample_valid_in;
            state_d = OUT;
         end
         OUT: begin
            if (sample_valid_in) begin
               accept  = 1'b1;
               state_d = ACCUM;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Mute wins over solo; resolved once at snapshot time.
   always_comb begin
      solo_any = |solo_in;
      en_in    = ~mute_in & (solo_any ? solo_in : '1);
   end

   always_comb begin
      smp_sel = data_q[idx_q*WIDTH +: WIDTH];
      vol_sel = vol_q[idx_q*VOL_WIDTH +: VOL_WIDTH];
      smp_ext = PW'(smp_sel);
      vol_ext = PW'($signed({1'b0, vol_sel}));
      prod    = smp_ext * vol_ext;
      term    = en_q[idx_q] ? AW'(prod) : '0;
   end

   always_comb begin
      acc_ext  = SW'(acc_q);
      mst_ext  = SW'($signed({1'b0, master_q}));
      prod_m   = acc_ext * mst_ext;
      scaled_d = prod_m >>> SH;
   end

   always_comb begin
      sat_d  = scaled_q[WIDTH-1:0];
      clip_d = 1'b0;
      if (scaled_q > MAXV) begin
         sat_d  = MAXV[WIDTH-1:0];
         clip_d = 1'b1;
      end else if (scaled_q < MINV) begin
         sat_d  = MINV[WIDTH-1:0];
         clip_d = 1'b1;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         data_q   <= '0;
         vol_q    <= '0;
         en_q     <= '0;
         master_q <= '0;
         acc_q    <= '0;
         idx_q    <= '0;
         scaled_q <= '0;
         wet_q    <= '0;
         valid_q  <= 1'b0;
         clip_q   <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         ovr_q   <= drop;
         if (accept) begin
            data_q   <= data_dry_in;
            vol_q    <= volume_in;
            en_q     <= en_in;
            master_q <= master_in;
            acc_q    <= '0;
            idx_q    <= '0;
         end else if (state_q == ACCUM) begin
            acc_q <= acc_q + term;
            idx_q <= idx_last ? '0 : idx_q + IW'(1);
         end
         if (state_q == SCALE) scaled_q <= scaled_d;
         if (state_q == OUT) begin
            wet_q   <= sat_d;
            clip_q  <= clip_d;
            valid_q <= 1'b1;
         end
      end
   end

   assign data_wet_out  = wet_q;
   assign wet_valid_out = valid_q;
   assign clip_out      = clip_q;
   assign overrun_out   = ovr_q;
   assign busy_out      = (state_q != IDLE);

endmodule

// File: doc/seq_mixer.md
# seq_mixer

Time-multiplexed, parametrised successor to the fixed-width channel mixer. It snapshots one frame of `CHANNELS` dry samples on a strobe and accumulates one channel per clock through a single multiplier. It then applies a master gain, saturates, and emits one wet sample with a valid pulse. It sits in the `clk_100` domain between `track_store_load` multi-channel read data and the 100→22 MHz clock-crossing path, and adds solo, master gain, clip and overrun reporting.

## Interface

**Parameters**
- `WIDTH`, default 8: signed two's-complement sample width, in and out.
- `CHANNELS`, default 8: number of mixed channels, ≥2.
- `VOL_WIDTH`, default 4: unsigned gain width; unity gain = 2^(VOL_WIDTH-1).

**Ports**
- `clk_in`, in, 1: system clock.
- `rst_in`, in, 1: reset, asynchronous, active-low.
- `sample_valid_in`, in, 1: one-cycle frame strobe.
- `data_dry_in`, in, CHANNELS*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
- `volume_in`, in, CHANNELS*VOL_WIDTH: per-channel gain.
- `mute_in`, in, CHANNELS: per-channel mute.
- `solo_in`, in, CHANNELS: per-channel solo.
- `master_in`, in, VOL_WIDTH: master gain.
- `data_wet_out`, out, WIDTH: mixed sample; holds its value between frames.
- `wet_valid_out`, out, 1: one-cycle pulse when `data_wet_out` updates.
- `clip_out`, out, 1: saturation occurred for this frame; qualified by `wet_valid_out` and held until the next frame.
- `overrun_out`, out, 1: one-cycle pulse when a strobe is dropped.
- `busy_out`, out, 1: high when state ≠ IDLE.

## Operation

**States**
- IDLE → ACCUM on an accepted strobe.
- ACCUM runs for `CHANNELS` cycles, index 0..CHANNELS-1, then → SCALE.
- SCALE runs 1 cycle, then → OUT.
- OUT runs 1 cycle, then → IDLE, or → ACCUM if a strobe is accepted in that cycle.

**Strobe acceptance**
- A strobe is accepted in IDLE or OUT.
- On acceptance, snapshot all data, volume, mute, solo and master inputs into registers, clear the accumulator and set index = 0.
- Input changes after acceptance have no effect on the frame in flight.

**Channel enable**
- `en[i] = !mute[i] && (solo_any ? solo[i] : 1)`, where `solo_any = |solo`, taken from the snapshot.
- Mute overrides solo.

**Arithmetic**
- ACCUM: `acc += en[i] ? sample[i] * $signed({1'b0, vol[i]}) : 0`.
- Accumulator width `AW = WIDTH + VOL_WIDTH + 1 + $clog2(CHANNELS)`; it can never overflow.
- SCALE: `scaled = (acc * $signed({1'b0, master})) >>> (2*(VOL_WIDTH-1))`. The shift is arithmetic (floor toward −∞), computed at width AW+VOL_WIDTH+1.
- OUT: saturate `scaled` to [−2^(WIDTH-1), 2^(WIDTH-1)−1].
  - Register the saturated value to `data_wet_out`.
  - Set `clip_out` = 1 if saturation occurred, else 0.
  - Pulse `wet_valid_out`.

**Overrun**
- A strobe in ACCUM or SCALE is ignored and `overrun_out` pulses in the next cycle.
- The frame in flight completes unaffected.

**Reset (asserted at any time, including mid-frame)**
- State = IDLE and accumulator = 0.
- `data_wet_out` = 0, `wet_valid_out` = 0, `clip_out` = 0, `overrun_out` = 0, `busy_out` = 0.
- The in-flight frame is discarded; no valid is emitted for it.

## Timing

- The strobe is sampled at edge E0. ACCUM occupies E1..E_C (C = CHANNELS), SCALE occupies E_{C+1}, and outputs register at E_{C+2}.
- `wet_valid_out` is high for exactly the one cycle following E_{C+2}. Latency is C+2 cycles.
- `busy_out` is high from E0 through the OUT cycle.
- Minimum strobe spacing is C+2 cycles, achieved by back-to-back acceptance in OUT. A strobe at spacing < C+2 produces an overrun.
- Single multiplier in ACCUM and a second multiplier in SCALE; no combinational path from inputs to outputs.

## Test plan

All scenarios use WIDTH=8, CHANNELS=4, VOL_WIDTH=4 (unity = 8).

1. **Unity mix:** all samples 10, volumes 8, master 8, single strobe → `data_wet_out` = 40, `clip_out` = 0, `wet_valid_out` high exactly 6 cycles after the strobe edge, `busy_out` high for 6 cycles.
2. **Saturation:** all samples 100, volumes 15, master 15 → 127 with `clip_out` = 1. All samples −100 with the same gains → −128 with `clip_out` = 1.
3. **Mute and solo:** samples 10/20/30/40, unity gains.
   - mute ch1 → 80.
   - solo ch2 → 30.
   - solo ch2+ch3 with mute ch3 → 30.
   - no mute/solo → 100.
4. **Floor rounding:** ch0 = −1 at volume 4, others muted, master 8 → −1. Same with ch0 = +1 → 0.
5. **Overrun and back-to-back:**
   - Second strobe 2 cycles after the first → `overrun_out` pulses once; the first result is correct; only one valid is emitted.
   - Strobes spaced exactly 6 cycles → both accepted, two valids 6 cycles apart, no overrun.
6. **Reset mid-frame:** assert `rst_in` low during ACCUM index 2 → all outputs 0 immediately and no valid. Release reset and strobe with scenario 1 inputs → 40 after 6 cycles.
